// File: rtl/ctrl_bubble_pipe.sv
// ID/EX control-bundle register with load-use hazard detection and bubble insertion.
// Optional macro CTRL_BUBBLE_STATS_EN adds a saturating 16-bit bubble counter (bubble_cnt_o).
module ctrl_bubble_pipe #(
  parameter int CTRL_W       = 8,
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              memread_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              memread_o,
  output logic [REG_AW-1:0] rd_o,
`ifdef CTRL_BUBBLE_STATS_EN
  output logic [15:0]       bubble_cnt_o,
`endif
  output logic              stall_o
);

  typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_t;

  // First STALL-state count after the hazard cycle itself supplied one bubble.
  localparam logic [2:0] CNT_INIT = 3'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);
  localparam bit         MULTI    = (STALL_CYCLES > 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_memread;
  logic [REG_AW-1:0]   r_rd;

  logic                w_hazard;
  logic                w_bubble;
  logic                w_ex_load;
  logic                w_ex_zero;
  logic [CTRL_W-1:0]   w_ctrl_nxt;
  logic                w_memread_nxt;
  logic [REG_AW-1:0]   w_rd_nxt;

  assign w_hazard = valid_i & r_memread & (r_rd != '0) &
                    ((r_rd == rs1_i) | (r_rd == rs2_i));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; w_bubble marks a hazard/STALL bubble (never flush or hold).
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bubble    = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
    end else if (!hold_i) begin
      case (r_state)
        S_RUN: begin
          if (w_hazard) begin
            w_bubble = 1'b1;
            if (MULTI) begin
              w_state_nxt = S_STALL;
              w_cnt_nxt   = CNT_INIT;
            end
          end
        end
        S_STALL: begin
          w_bubble = 1'b1;
          if (r_cnt == '0) w_state_nxt = S_RUN;
          else             w_cnt_nxt   = r_cnt - 3'd1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall_o       = ~rst_i & ~flush_i & (hold_i | w_bubble);
    w_ex_load     = flush_i | ~hold_i;
    w_ex_zero     = flush_i | w_bubble | ~valid_i;
    w_ctrl_nxt    = w_ex_zero ? '0   : ctrl_i;
    w_memread_nxt = w_ex_zero ? 1'b0 : memread_i;
    w_rd_nxt      = w_ex_zero ? '0   : rd_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl    <= '0;
      r_memread <= 1'b0;
      r_rd      <= '0;
    end else if (w_ex_load) begin
      r_ctrl    <= w_ctrl_nxt;
      r_memread <= w_memread_nxt;
      r_rd      <= w_rd_nxt;
    end
  end

  assign ctrl_o    = r_ctrl;
  assign memread_o = r_memread;
  assign rd_o      = r_rd;

`ifdef CTRL_BUBBLE_STATS_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Bench for ctrl_bubble_pipe: two instances (STALL_CYCLES = 1 and 3) driven one at a time,
// expected EX bundles queued at drive time and compared after the clock edge.
module tb_ctrl_bubble_pipe;

  typedef struct packed {
    logic       valid;
    logic [7:0] ctrl;
    logic       memread;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       flush;
    logic       hold;
  } id_t;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       memread;
    logic [4:0] rd;
  } ex_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;

  logic       valid_a   [2];
  logic [7:0] ctrl_a    [2];
  logic       memread_a [2];
  logic [4:0] rs1_a     [2];
  logic [4:0] rs2_a     [2];
  logic [4:0] rd_a      [2];
  logic       flush_a   [2];
  logic       hold_a    [2];

  logic [7:0] ctrl_oa    [2];
  logic       memread_oa [2];
  logic [4:0] rd_oa      [2];
  logic       stall_oa   [2];
  logic [15:0] bub_oa    [2];

  int n_checks = 0;
  int n_errors = 0;
  int exp_bub [2];
  ex_t sb_q [$];

  always #5 clk_i = ~clk_i;

  ctrl_bubble_pipe #(.CTRL_W(8), .REG_AW(5), .STALL_CYCLES(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_a[0]), .ctrl_i(ctrl_a[0]),
    .memread_i(memread_a[0]), .rs1_i(rs1_a[0]), .rs2_i(rs2_a[0]), .rd_i(rd_a[0]),
    .flush_i(flush_a[0]), .hold_i(hold_a[0]), .ctrl_o(ctrl_oa[0]),
    .memread_o(memread_oa[0]), .rd_o(rd_oa[0]),
`ifdef CTRL_BUBBLE_STATS_EN
    .bubble_cnt_o(bub_oa[0]),
`endif
    .stall_o(stall_oa[0])
  );

  ctrl_bubble_pipe #(.CTRL_W(8), .REG_AW(5), .STALL_CYCLES(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_a[1]), .ctrl_i(ctrl_a[1]),
    .memread_i(memread_a[1]), .rs1_i(rs1_a[1]), .rs2_i(rs2_a[1]), .rd_i(rd_a[1]),
    .flush_i(flush_a[1]), .hold_i(hold_a[1]), .ctrl_o(ctrl_oa[1]),
    .memread_o(memread_oa[1]), .rd_o(rd_oa[1]),
`ifdef CTRL_BUBBLE_STATS_EN
    .bubble_cnt_o(bub_oa[1]),
`endif
    .stall_o(stall_oa[1])
  );

`ifndef CTRL_BUBBLE_STATS_EN
  initial begin
    bub_oa[0] = '0;
    bub_oa[1] = '0;
  end
`endif

  function automatic id_t mk(input logic v, input logic [7:0] c, input logic mr,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic fl, input logic hd);
    id_t s;
    s.valid = v; s.ctrl = c; s.memread = mr; s.rs1 = r1; s.rs2 = r2; s.rd = rd;
    s.flush = fl; s.hold = hd;
    return s;
  endfunction

  function automatic ex_t ex(input logic [7:0] c, input logic mr, input logic [4:0] rd);
    ex_t e;
    e.ctrl = c; e.memread = mr; e.rd = rd;
    return e;
  endfunction

  task automatic apply(input int d, input id_t s);
    valid_a[d]   = s.valid;
    ctrl_a[d]    = s.ctrl;
    memread_a[d] = s.memread;
    rs1_a[d]     = s.rs1;
    rs2_a[d]     = s.rs2;
    rd_a[d]      = s.rd;
    flush_a[d]   = s.flush;
    hold_a[d]    = s.hold;
  endtask

  // One ID cycle on instance d: check combinational stall_o, then the EX bundle after the edge.
  task automatic cycle(input int d, input id_t s, input logic exp_stall, input ex_t exp_ex,
                       input string nm);
    ex_t got;
    ex_t want;
    @(negedge clk_i);
    apply(d, s);
    apply(1 - d, '0);
    #1;
    n_checks++;
    if (stall_oa[d] !== exp_stall) begin
      n_errors++;
      $display("FAIL %s stall_o got %0b expected %0b", nm, stall_oa[d], exp_stall);
    end
    sb_q.push_back(exp_ex);
    @(posedge clk_i);
    #1;
    got  = {ctrl_oa[d], memread_oa[d], rd_oa[d]};
    want = sb_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s ex ctrl/mr/rd got %h/%0b/%0d expected %h/%0b/%0d", nm,
               got.ctrl, got.memread, got.rd, want.ctrl, want.memread, want.rd);
    end
  endtask

  task automatic check_bub(input int d, input string nm);
`ifdef CTRL_BUBBLE_STATS_EN
    n_checks++;
    if (bub_oa[d] !== 16'(exp_bub[d])) begin
      n_errors++;
      $display("FAIL %s bubble_cnt_o got %0d expected %0d", nm, bub_oa[d], exp_bub[d]);
    end
`else
    if (nm.len() == 0) $display("bubble check on instance %0d", d);
`endif
  endtask

  task automatic test_reset;
    apply(0, mk(1, 8'hFF, 1, 5'd1, 5'd1, 5'd1, 0, 1));
    apply(1, mk(1, 8'hFF, 1, 5'd1, 5'd1, 5'd1, 0, 1));
    repeat (2) @(posedge clk_i);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (stall_oa[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_stall[%0d] got %0b expected 0", d, stall_oa[d]);
      end
      n_checks++;
      if ({ctrl_oa[d], memread_oa[d], rd_oa[d]} !== 14'd0) begin
        n_errors++;
        $display("FAIL reset_ex[%0d] got %h/%0b/%0d expected 0/0/0", d,
                 ctrl_oa[d], memread_oa[d], rd_oa[d]);
      end
      exp_bub[d] = 0;
      check_bub(d, "reset_bub");
    end
    @(negedge clk_i);
    apply(0, '0);
    apply(1, '0);
    rst_i = 1'b0;
  endtask

  task automatic test_pass;
    cycle(0, mk(1, 8'hA5, 0, 5'd1, 5'd2, 5'd3, 0, 0), 0, ex(8'hA5, 0, 5'd3), "pass_a5");
    cycle(0, mk(0, 8'h3C, 1, 5'd3, 5'd3, 5'd4, 0, 0), 0, ex(8'h00, 0, 5'd0), "pass_invalid");
  endtask

  task automatic test_hold_run;
    cycle(0, mk(1, 8'h66, 0, 5'd1, 5'd2, 5'd8, 0, 0), 0, ex(8'h66, 0, 5'd8), "hold_run_pre");
    cycle(0, mk(1, 8'h77, 0, 5'd1, 5'd2, 5'd9, 0, 1), 1, ex(8'h66, 0, 5'd8), "hold_run_frozen");
    cycle(0, mk(1, 8'h77, 0, 5'd1, 5'd2, 5'd9, 0, 0), 0, ex(8'h77, 0, 5'd9), "hold_run_release");
  endtask

  task automatic test_load_use_1;
    cycle(0, mk(1, 8'h11, 1, 5'd1, 5'd2, 5'd5, 0, 0), 0, ex(8'h11, 1, 5'd5), "lu1_load");
    cycle(0, mk(1, 8'h22, 0, 5'd5, 5'd0, 5'd6, 0, 0), 1, ex(8'h00, 0, 5'd0), "lu1_bubble");
    exp_bub[0] += 1;
    cycle(0, mk(1, 8'h22, 0, 5'd5, 5'd0, 5'd6, 0, 0), 0, ex(8'h22, 0, 5'd6), "lu1_dep");
    check_bub(0, "lu1_bub");
  endtask

  task automatic test_rd_zero;
    cycle(0, mk(1, 8'h33, 1, 5'd0, 5'd0, 5'd0, 0, 0), 0, ex(8'h33, 1, 5'd0), "rd0_load");
    cycle(0, mk(1, 8'h44, 0, 5'd0, 5'd0, 5'd7, 0, 0), 0, ex(8'h44, 0, 5'd7), "rd0_dep");
    check_bub(0, "rd0_bub");
  endtask

  task automatic test_flush_hazard;
    cycle(0, mk(1, 8'h55, 1, 5'd1, 5'd1, 5'd7, 0, 0), 0, ex(8'h55, 1, 5'd7), "fl_load");
    cycle(0, mk(1, 8'h66, 0, 5'd2, 5'd7, 5'd8, 1, 0), 0, ex(8'h00, 0, 5'd0), "fl_flush");
    cycle(0, mk(1, 8'h66, 0, 5'd2, 5'd7, 5'd8, 0, 0), 0, ex(8'h66, 0, 5'd8), "fl_after");
    check_bub(0, "fl_bub");
  endtask

  task automatic test_load_use_3;
    cycle(1, mk(1, 8'hA1, 1, 5'd1, 5'd2, 5'd4, 0, 0), 0, ex(8'hA1, 1, 5'd4), "lu3_load");
    for (int i = 0; i < 3; i++) begin
      cycle(1, mk(1, 8'hB2, 0, 5'd3, 5'd4, 5'd12, 0, 0), 1, ex(8'h00, 0, 5'd0), "lu3_bubble");
      exp_bub[1] += 1;
    end
    cycle(1, mk(1, 8'hB2, 0, 5'd3, 5'd4, 5'd12, 0, 0), 0, ex(8'hB2, 0, 5'd12), "lu3_dep");
    check_bub(1, "lu3_bub");
  endtask

  task automatic test_hold_stall;
    id_t dep;
    dep = mk(1, 8'h92, 0, 5'd9, 5'd1, 5'd10, 0, 0);
    cycle(1, mk(1, 8'h91, 1, 5'd1, 5'd2, 5'd9, 0, 0), 0, ex(8'h91, 1, 5'd9), "hs_load");
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "hs_bubble0");
    exp_bub[1] += 1;
    dep.hold = 1'b1;
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "hs_hold0");
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "hs_hold1");
    dep.hold = 1'b0;
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "hs_bubble1");
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "hs_bubble2");
    exp_bub[1] += 2;
    cycle(1, dep, 0, ex(8'h92, 0, 5'd10), "hs_dep");
    check_bub(1, "hs_bub");
  endtask

  task automatic test_async_reset;
    id_t dep;
    cycle(0, mk(1, 8'hC3, 0, 5'd1, 5'd2, 5'd13, 0, 0), 0, ex(8'hC3, 0, 5'd13), "ar_pass");
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({ctrl_oa[0], memread_oa[0], rd_oa[0]} !== 14'd0) begin
      n_errors++;
      $display("FAIL ar_clear ex got %h/%0b/%0d expected 0/0/0",
               ctrl_oa[0], memread_oa[0], rd_oa[0]);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_bub[0] = 0;
    exp_bub[1] = 0;

    dep = mk(1, 8'hD4, 0, 5'd11, 5'd2, 5'd14, 0, 0);
    cycle(1, mk(1, 8'hD3, 1, 5'd1, 5'd2, 5'd11, 0, 0), 0, ex(8'hD3, 1, 5'd11), "ar_load");
    cycle(1, dep, 1, ex(8'h00, 0, 5'd0), "ar_bubble");
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (stall_oa[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_stall_clear stall_o got %0b expected 0", stall_oa[1]);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    cycle(1, dep, 0, ex(8'hD4, 0, 5'd14), "ar_run_after");
    check_bub(1, "ar_bub");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pass();
    test_hold_run();
    test_load_use_1();
    test_rd_zero();
    test_flush_hazard();
    test_load_use_3();
    test_hold_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_bubble_pipe.md
# ctrl_bubble_pipe

Parametrised ID/EX control-bundle pipeline register with built-in load-use hazard detection and bubble insertion. It is the successor to the combinational control-zeroing mux. It owns the EX-stage copy of the control bundle and destination register, and detects load-use hazards against it. It stalls PC and IF/ID for a configurable number of cycles and zeroes the bundle on stall or branch flush. It sits between the ID-stage decoder and the EX stage of the CPU pipeline.

## Interface
Parameters:
- CTRL_W, 8, width of the packed control bundle (ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg).
- REG_AW, 5, register-index width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  ID stage holds a real instruction.
- ctrl_i  in  CTRL_W  decoded control bundle from ID.
- memread_i  in  1  ID instruction is a load.
- rs1_i  in  REG_AW  ID source register 1.
- rs2_i  in  REG_AW  ID source register 2.
- rd_i  in  REG_AW  ID destination register.
- flush_i  in  1  branch taken; kill the ID instruction.
- hold_i  in  1  external freeze (e.g. memory wait).
- ctrl_o  out  CTRL_W  registered EX control bundle.
- memread_o  out  1  registered EX load flag.
- rd_o  out  REG_AW  registered EX destination.
- stall_o  out  1  combinational; disables PC and IF/ID writes.
- bubble_cnt_o  out  16  bubbles inserted; present only with the stats macro.

## Operation
- The FSM has two states, RUN and STALL. A 3-bit down-counter `cnt` is used in STALL.
- hazard = valid_i & memread_o & (rd_o != 0) & (rd_o == rs1_i | rd_o == rs2_i).
- Priority is flush_i > hold_i > hazard/STALL > normal.
- flush_i:
  - EX register loads all-zero: ctrl_o = 0, memread_o = 0, rd_o = 0.
  - FSM goes to RUN and cnt is cleared. stall_o = 0.
  - A flush does not count as a bubble.
- hold_i (no flush):
  - EX register, FSM and cnt all hold their values.
  - stall_o = 1.
- RUN with hazard:
  - EX register loads zero (bubble) and stall_o = 1.
  - If STALL_CYCLES > 1, go to STALL with cnt = STALL_CYCLES-2. Otherwise stay in RUN.
- RUN without hazard: EX register loads {ctrl_i, memread_i, rd_i}, gated to zero when valid_i = 0. stall_o = 0.
- STALL:
  - EX register loads zero and stall_o = 1.
  - If cnt == 0, go to RUN. Otherwise cnt decrements.
- After a bubble, memread_o = 0, so the held instruction re-evaluates cleanly in RUN and proceeds.
- rd_i = 0 is never treated as a hazard source.

## Timing
- Reset values: ctrl_o = 0, memread_o = 0, rd_o = 0, state RUN, cnt = 0, bubble_cnt_o = 0.
- stall_o = 0 while rst_i = 1, regardless of hold_i.
- Reset is asynchronous mid-stall: outputs clear immediately and the FSM returns to RUN.
- stall_o is combinational in the same cycle as the ID inputs. The bubble appears on ctrl_o one cycle later.
- Pass-through latency is 1 cycle from ctrl_i to ctrl_o.
- A load-use pair costs exactly STALL_CYCLES stall cycles. The dependent instruction reaches ctrl_o STALL_CYCLES+1 cycles after the load.
- flush_i and hazard in the same cycle: the flush wins, with no stall and no bubble count.
- hold_i during STALL: cnt is frozen, and the remaining bubble count is preserved after hold_i drops.

## Configuration
- Macro CTRL_BUBBLE_STATS_EN.
- Defined:
  - bubble_cnt_o is a 16-bit counter that increments on every cycle a hazard/STALL bubble is loaded (not flush, not hold).
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the bubble_cnt_o port and its counter are absent.

## Test plan
- Reset, then ctrl_i = 8'hA5, rd_i = 3, valid_i = 1, no hazard → ctrl_o = 8'hA5, rd_o = 3 after 1 cycle; stall_o = 0.
- Load (memread_i = 1, rd_i = 5) followed by rs1_i = 5 with STALL_CYCLES = 1 → stall_o = 1 for 1 cycle, ctrl_o = 0 for one cycle, then the dependent bundle passes; bubble_cnt_o = 1.
- Same sequence with STALL_CYCLES = 3 → stall_o high for 3 consecutive cycles, 3 zero bundles, bubble_cnt_o = 3.
- Load with rd_i = 0 followed by rs1_i = 0 → no stall; bubble_cnt_o unchanged.
- Hazard and flush_i in the same cycle → stall_o = 0, ctrl_o = 0, FSM in RUN, bubble_cnt_o unchanged.
- STALL_CYCLES = 3; hold_i = 1 for 2 cycles mid-stall, then rst_i pulsed asynchronously during a later stall → hold extends total stall_o to 5 cycles with ctrl_o frozen; reset clears ctrl_o and stall_o immediately.
